// File: rtl/bsg_comm_link_bringup_seq.sv
// Comm-link bring-up sequencer: holds link reset, calibrates each enabled channel
// in turn with a timeout, then releases core reset, retries, or latches failure.
module bsg_comm_link_bringup_seq #(
  parameter int                    channels_p             = 4,
  parameter logic [channels_p-1:0] enabled_at_start_vec_p = {channels_p{1'b1}},
  parameter int                    reset_cycles_p         = 16,
  parameter int                    timeout_p              = 1024,
  parameter int                    min_channels_p         = 1,
  parameter int                    max_retries_p          = 3
) (
  input  logic                  clk_i,
  input  logic                  async_reset_i,
  output logic [channels_p-1:0] cal_req_o,
  input  logic [channels_p-1:0] cal_done_i,
  input  logic [channels_p-1:0] cal_pass_i,
  input  logic                  recal_i,
  output logic                  link_reset_o,
  output logic                  core_reset_o,
  output logic [channels_p-1:0] channel_active_o,
  output logic                  fail_o,
  output logic [2:0]            state_o
);

  localparam int idx_w   = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int hold_w  = $clog2(reset_cycles_p + 1);
  localparam int timer_w = $clog2(timeout_p + 1);
  localparam int retry_w = (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1;
  localparam int pop_w   = $clog2(channels_p + 1);

  localparam logic [idx_w-1:0]      idx_last_c   = idx_w'(channels_p - 1);
  localparam logic [hold_w-1:0]     hold_last_c  = hold_w'(reset_cycles_p - 1);
  localparam logic [timer_w-1:0]    timer_last_c = timer_w'(timeout_p - 1);
  localparam logic [retry_w-1:0]    retry_max_c  = retry_w'(max_retries_p);
  localparam logic [pop_w-1:0]      min_pass_c   = pop_w'(min_channels_p);
  localparam logic [channels_p-1:0] req_one_c    = channels_p'(1);

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_SELECT     = 3'd1,
    S_CAL_WAIT   = 3'd2,
    S_CHECK      = 3'd3,
    S_RUN        = 3'd4,
    S_FAIL       = 3'd5
  } state_e;

  state_e                  state_q,  state_d;
  logic [idx_w-1:0]        idx_q,    idx_d;
  logic [hold_w-1:0]       hold_q,   hold_d;
  logic [timer_w-1:0]      timer_q,  timer_d;
  logic [retry_w-1:0]      retry_q,  retry_d;
  logic [channels_p-1:0]   cal_req_q, cal_req_d;
  logic [channels_p-1:0]   active_q, active_d;
  logic                    link_reset_q, link_reset_d;
  logic                    core_reset_q, core_reset_d;
  logic                    fail_q,   fail_d;
  logic [pop_w-1:0]        pass_count;
  logic                    cal_finished;

  always_comb begin
    pass_count = '0;
    for (int i = 0; i < channels_p; i++) begin
      pass_count = pass_count + pop_w'(active_q[i]);
    end
  end

  // Only the selected channel's done matters; done takes priority over timeout.
  assign cal_finished = cal_done_i[idx_q] || (timer_q == timer_last_c);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    cal_req_d    = cal_req_q;
    active_d     = active_q;
    link_reset_d = link_reset_q;
    core_reset_d = core_reset_q;
    fail_d       = fail_q;

    case (state_q)
      S_RESET_HOLD: begin
        link_reset_d = 1'b1;
        core_reset_d = 1'b1;
        if (hold_q == hold_last_c) begin
          state_d      = S_SELECT;
          hold_d       = '0;
          idx_d        = '0;
          active_d     = '0;
          link_reset_d = 1'b0;
        end else begin
          hold_d = hold_q + hold_w'(1);
        end
      end

      S_SELECT: begin
        if (enabled_at_start_vec_p[idx_q]) begin
          state_d   = S_CAL_WAIT;
          timer_d   = '0;
          cal_req_d = req_one_c << idx_q;
        end else if (idx_q == idx_last_c) begin
          state_d = S_CHECK;
        end else begin
          idx_d = idx_q + idx_w'(1);
        end
      end

      S_CAL_WAIT: begin
        if (cal_finished) begin
          active_d[idx_q] = cal_done_i[idx_q] & cal_pass_i[idx_q];
          cal_req_d       = '0;
          if (idx_q == idx_last_c) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_SELECT;
            idx_d   = idx_q + idx_w'(1);
          end
        end else begin
          timer_d = timer_q + timer_w'(1);
        end
      end

      S_CHECK: begin
        if (pass_count >= min_pass_c) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
        end else if (retry_q < retry_max_c) begin
          state_d      = S_RESET_HOLD;
          retry_d      = retry_q + retry_w'(1);
          hold_d       = '0;
          link_reset_d = 1'b1;
        end else begin
          state_d      = S_FAIL;
          fail_d       = 1'b1;
          link_reset_d = 1'b1;
        end
      end

      S_RUN: begin
        if (recal_i) begin
          state_d      = S_RESET_HOLD;
          hold_d       = '0;
          retry_d      = '0;
          active_d     = '0;
          link_reset_d = 1'b1;
          core_reset_d = 1'b1;
        end
      end

      S_FAIL: begin
        if (recal_i) begin
          state_d = S_RESET_HOLD;
          hold_d  = '0;
          retry_d = '0;
          fail_d  = 1'b0;
        end
      end

      default: begin
        state_d      = S_RESET_HOLD;
        hold_d       = '0;
        cal_req_d    = '0;
        link_reset_d = 1'b1;
        core_reset_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q      <= S_RESET_HOLD;
      idx_q        <= '0;
      hold_q       <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      cal_req_q    <= '0;
      active_q     <= '0;
      link_reset_q <= 1'b1;
      core_reset_q <= 1'b1;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cal_req_q    <= cal_req_d;
      active_q     <= active_d;
      link_reset_q <= link_reset_d;
      core_reset_q <= core_reset_d;
      fail_q       <= fail_d;
    end
  end

  assign cal_req_o        = cal_req_q;
  assign link_reset_o     = link_reset_q;
  assign core_reset_o     = core_reset_q;
  assign channel_active_o = active_q;
  assign fail_o           = fail_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_bsg_comm_link_bringup_seq.sv
// Directed bench for bsg_comm_link_bringup_seq: default instance plus a sparse-mask,
// short-timeout instance. Cycle n is the period ending at rising edge n after reset release.
module tb_bsg_comm_link_bringup_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int run0   = 0;
  logic stray_en = 1'b0;

  // Default-parameter instance
  logic       rst0, recal0, lr0, cr0, fail0;
  logic [3:0] req0, done0, pass0, act0;
  logic [2:0] st0;

  bsg_comm_link_bringup_seq u0 (
    .clk_i            (clk),
    .async_reset_i    (rst0),
    .cal_req_o        (req0),
    .cal_done_i       (done0),
    .cal_pass_i       (pass0),
    .recal_i          (recal0),
    .link_reset_o     (lr0),
    .core_reset_o     (cr0),
    .channel_active_o (act0),
    .fail_o           (fail0),
    .state_o          (st0)
  );

  // Channels 0 and 2 enabled, 8-cycle timeout
  logic       rst1, recal1, lr1, cr1, fail1;
  logic [3:0] req1, done1, pass1, act1;
  logic [2:0] st1;

  bsg_comm_link_bringup_seq #(
    .channels_p             (4),
    .enabled_at_start_vec_p (4'b0101),
    .reset_cycles_p         (16),
    .timeout_p              (8),
    .min_channels_p         (1),
    .max_retries_p          (3)
  ) u1 (
    .clk_i            (clk),
    .async_reset_i    (rst1),
    .cal_req_o        (req1),
    .cal_done_i       (done1),
    .cal_pass_i       (pass1),
    .recal_i          (recal1),
    .link_reset_o     (lr1),
    .core_reset_o     (cr1),
    .channel_active_o (act1),
    .fail_o           (fail1),
    .state_o          (st1)
  );

  // Responder for u0: answers on the done_at-th cycle of each request (0 = never).
  task automatic observe0(input logic [3:0] pass_mask, input int done_at);
    if (req0 != 4'b0000) run0++;
    else run0 = 0;
    done0 = (done_at != 0 && run0 == done_at) ? req0 : 4'b0000;
    if (stray_en && run0 == 1) done0 = {req0[2:0], req0[3]};
    pass0 = pass_mask;
  endtask

  task automatic tick0(input logic [3:0] pass_mask, input int done_at);
    @(negedge clk);
    cyc++;
    observe0(pass_mask, done_at);
  endtask

  task automatic walk0(input logic [3:0] pass_mask, input int done_at, input int target);
    while (cyc < target) tick0(pass_mask, done_at);
  endtask

  task automatic hold_reset0;
    rst0 = 1'b1; recal0 = 1'b0; done0 = 4'b0; pass0 = 4'b0; stray_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release0(input logic [3:0] pass_mask, input int done_at);
    @(negedge clk);
    rst0 = 1'b0;
    cyc  = 1;
    run0 = 0;
    observe0(pass_mask, done_at);
  endtask

  task automatic test_reset;
    hold_reset0;
    checks++;
    if ({st0, lr0, cr0, req0, act0, fail0} !== {3'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: st=%0d lr=%b cr=%b req=%b act=%b fail=%b, want st=0 lr=1 cr=1 req=0000 act=0000 fail=0",
               st0, lr0, cr0, req0, act0, fail0);
    end
  endtask

  task automatic test_normal;
    logic [3:0] exp_req;
    hold_reset0;
    release0(4'hF, 3);
    while (cyc <= 34) begin
      exp_req = 4'b0000;
      if (cyc >= 18 && cyc <= 32 && ((cyc - 18) % 4) != 3) exp_req = 4'b0001 << ((cyc - 18) / 4);
      checks++;
      if (req0 !== exp_req) begin
        errors++;
        $display("FAIL normal_req cyc %0d: got %b want %b", cyc, req0, exp_req);
      end
      if (cyc == 16 || cyc == 17) begin
        checks++;
        if ({st0, lr0} !== ((cyc == 16) ? {3'd0, 1'b1} : {3'd1, 1'b0})) begin
          errors++;
          $display("FAIL normal_hold_exit cyc %0d: st=%0d lr=%b", cyc, st0, lr0);
        end
      end
      if (cyc == 33) begin
        checks++;
        if ({st0, cr0} !== {3'd3, 1'b1}) begin
          errors++;
          $display("FAIL normal_check cyc 33: st=%0d cr=%b want st=3 cr=1", st0, cr0);
        end
      end
      if (cyc == 34) begin
        checks++;
        if ({st0, cr0, lr0, act0} !== {3'd4, 1'b0, 1'b0, 4'b1111}) begin
          errors++;
          $display("FAIL normal_run cyc 34: st=%0d cr=%b lr=%b act=%b want 4 0 0 1111", st0, cr0, lr0, act0);
        end
      end
      tick0(4'hF, 3);
    end
  endtask

  // Starts in RUN (left there by test_normal).
  task automatic test_recal_run;
    recal0 = 1'b1;
    tick0(4'hF, 3);
    recal0 = 1'b0;
    cyc = 1;
    checks++;
    if ({st0, cr0, lr0, act0} !== {3'd0, 1'b1, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL recal_from_run: st=%0d cr=%b lr=%b act=%b want 0 1 1 0000", st0, cr0, lr0, act0);
    end
    walk0(4'hF, 3, 19);
    recal0 = 1'b1;
    tick0(4'hF, 3);
    recal0 = 1'b0;
    checks++;
    if ({st0, req0} !== {3'd2, 4'b0001}) begin
      errors++;
      $display("FAIL recal_in_cal_wait: st=%0d req=%b want 2 0001", st0, req0);
    end
    walk0(4'hF, 3, 34);
    checks++;
    if ({st0, act0, cr0} !== {3'd4, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL recal_rerun: st=%0d act=%b cr=%b want 4 1111 0", st0, act0, cr0);
    end
  endtask

  task automatic test_retry_fail;
    int   hold_cycles;
    int   entries;
    logic [2:0] prev_st;
    hold_cycles = 0;
    entries     = 0;
    prev_st     = 3'd7;
    hold_reset0;
    release0(4'h0, 3);
    while (cyc <= 133) begin
      if (st0 == 3'd0 && lr0 == 1'b1) hold_cycles++;
      if (st0 == 3'd0 && prev_st != 3'd0) entries++;
      prev_st = st0;
      if (cyc == 133) begin
        checks++;
        if ({st0, fail0, cr0, lr0} !== {3'd5, 1'b1, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL retry_fail_state: st=%0d fail=%b cr=%b lr=%b want 5 1 1 1", st0, fail0, cr0, lr0);
        end
      end
      tick0(4'h0, 3);
    end
    checks++;
    if (hold_cycles !== 64) begin
      errors++;
      $display("FAIL retry_hold_cycles: got %0d want 64", hold_cycles);
    end
    checks++;
    if (entries !== 4) begin
      errors++;
      $display("FAIL retry_hold_entries: got %0d want 4", entries);
    end
    recal0 = 1'b1;
    tick0(4'hF, 3);
    recal0 = 1'b0;
    cyc = 1;
    checks++;
    if ({st0, fail0} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL recal_from_fail: st=%0d fail=%b want 0 0", st0, fail0);
    end
    walk0(4'hF, 3, 34);
    checks++;
    if ({st0, fail0, act0, cr0} !== {3'd4, 1'b0, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL fail_then_run: st=%0d fail=%b act=%b cr=%b want 4 0 1111 0", st0, fail0, act0, cr0);
    end
  endtask

  task automatic test_ignore_other_done;
    hold_reset0;
    stray_en = 1'b1;
    release0(4'hF, 3);
    walk0(4'hF, 3, 19);
    checks++;
    if (req0 !== 4'b0001) begin
      errors++;
      $display("FAIL stray_done_ignored: req=%b want 0001", req0);
    end
    walk0(4'hF, 3, 34);
    stray_en = 1'b0;
    checks++;
    if ({st0, act0} !== {3'd4, 4'b1111}) begin
      errors++;
      $display("FAIL stray_done_run: st=%0d act=%b want 4 1111", st0, act0);
    end
  endtask

  task automatic test_done_on_timeout;
    hold_reset0;
    release0(4'hF, 1024);
    walk0(4'hF, 1024, 1041);
    checks++;
    if (req0 !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_edge_req: req=%b want 0001", req0);
    end
    walk0(4'hF, 1024, 4118);
    checks++;
    if ({st0, act0} !== {3'd4, 4'b1111}) begin
      errors++;
      $display("FAIL done_beats_timeout: st=%0d act=%b want 4 1111", st0, act0);
    end
  endtask

  task automatic test_async_reset;
    hold_reset0;
    release0(4'hF, 3);
    walk0(4'hF, 3, 27);
    checks++;
    if ({st0, req0} !== {3'd2, 4'b0100}) begin
      errors++;
      $display("FAIL async_pre: st=%0d req=%b want 2 0100", st0, req0);
    end
    #2 rst0 = 1'b1;
    #1;
    checks++;
    if ({st0, lr0, cr0, req0, act0, fail0} !== {3'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_values: st=%0d lr=%b cr=%b req=%b act=%b fail=%b", st0, lr0, cr0, req0, act0, fail0);
    end
    release0(4'hF, 3);
    walk0(4'hF, 3, 16);
    checks++;
    if ({st0, lr0} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_hold_16: st=%0d lr=%b want 0 1", st0, lr0);
    end
    tick0(4'hF, 3);
    checks++;
    if ({st0, lr0} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL async_hold_exit: st=%0d lr=%b want 1 0", st0, lr0);
    end
  endtask

  task automatic test_skip_timeout;
    int run1;
    int ch2_cycles;
    run1 = 0;
    ch2_cycles = 0;
    rst1 = 1'b1; done1 = 4'b0; pass1 = 4'hF; recal1 = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    cyc  = 1;
    while (cyc <= 33) begin
      if (req1 != 4'b0000) run1++;
      else run1 = 0;
      done1 = (run1 == 3 && req1 == 4'b0001) ? 4'b0001 : 4'b0000;
      if (req1 == 4'b0100) ch2_cycles++;
      if (cyc == 30 || cyc == 31) begin
        checks++;
        if (req1 !== ((cyc == 30) ? 4'b0100 : 4'b0000)) begin
          errors++;
          $display("FAIL skip_timeout_req cyc %0d: req=%b", cyc, req1);
        end
      end
      if (cyc == 32) begin
        checks++;
        if (st1 !== 3'd3) begin
          errors++;
          $display("FAIL skip_check cyc 32: st=%0d want 3", st1);
        end
      end
      if (cyc == 33) begin
        checks++;
        if ({st1, act1, cr1} !== {3'd4, 4'b0001, 1'b0}) begin
          errors++;
          $display("FAIL skip_run cyc 33: st=%0d act=%b cr=%b want 4 0001 0", st1, act1, cr1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ch2_cycles !== 8) begin
      errors++;
      $display("FAIL timeout_req_len: got %0d want 8", ch2_cycles);
    end
  endtask

  initial begin
    rst0 = 1'b1; recal0 = 1'b0; done0 = 4'b0; pass0 = 4'b0;
    rst1 = 1'b1; recal1 = 1'b0; done1 = 4'b0; pass1 = 4'b0;
    test_reset;
    test_normal;
    test_recal_run;
    test_retry_fail;
    test_ignore_other_done;
    test_done_on_timeout;
    test_async_reset;
    test_skip_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
